// File: rtl/fp_compare_unit.sv
// fp_compare_unit
//   Pipelined, multi-lane IEEE-754 single-precision compare / min / max unit.
//
//   Stage 1 decodes the operation and classifies every operand as NaN or
//   signalling NaN. Any middle stages are plain registers. The final stage
//   does the ordering compare and the result select, and its registers drive
//   the outputs directly. With LATENCY=1 all of this logic sits in one stage.
//
//   The whole pipeline advances together whenever the output register is
//   empty or is being consumed (adv). Empty stages move through as bubbles.
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-low reset
//   in_valid    operation present on the input
//   in_ready    unit accepts an operation this cycle
//   in_op       0=LT 1=LTE 2=EQ 3=MIN 4=MAX, 5..7 reserved
//   in_a, in_b  LANES packed 32-bit operands, lane i = bits [32i+31:32i]
//   in_tag      opaque tag carried with the operation
//   out_valid   result present
//   out_ready   consumer accepts the result this cycle
//   out_q       per-lane result (compares return {31'b0, bit})
//   out_invalid per-lane invalid-operation (NV) flag
//   out_tag     tag of the result
module fp_compare_unit #(
  parameter int LATENCY   = 2,
  parameter int LANES     = 4,
  parameter int TAG_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [LANES*32-1:0]    in_a,
  input  logic [LANES*32-1:0]    in_b,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*32-1:0]    out_q,
  output logic [LANES-1:0]       out_invalid,
  output logic [TAG_WIDTH-1:0]   out_tag
);

  // One-hot operation decode; all-zero means a reserved opcode.
  localparam logic [4:0] OH_LT  = 5'b00001;
  localparam logic [4:0] OH_LTE = 5'b00010;
  localparam logic [4:0] OH_EQ  = 5'b00100;
  localparam logic [4:0] OH_MIN = 5'b01000;
  localparam logic [4:0] OH_MAX = 5'b10000;

  typedef struct packed {
    logic [4:0]           op_oh;
    logic [TAG_WIDTH-1:0] tag;
    logic [LANES*32-1:0]  a;
    logic [LANES*32-1:0]  b;
    logic [LANES-1:0]     nan_a;
    logic [LANES-1:0]     snan_a;
    logic [LANES-1:0]     nan_b;
    logic [LANES-1:0]     snan_b;
  } stage_t;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------- decode
  logic [LANES-1:0] nan_a_c, snan_a_c, nan_b_c, snan_b_c;
  stage_t           dec_c;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_class
      // NaN: all-ones exponent with non-zero mantissa; quiet bit is m[22].
      assign nan_a_c[gi]  = (in_a[32*gi+23 +: 8] == 8'hFF) && (in_a[32*gi +: 23] != 23'd0);
      assign nan_b_c[gi]  = (in_b[32*gi+23 +: 8] == 8'hFF) && (in_b[32*gi +: 23] != 23'd0);
      assign snan_a_c[gi] = nan_a_c[gi] && !in_a[32*gi+22];
      assign snan_b_c[gi] = nan_b_c[gi] && !in_b[32*gi+22];
    end
  endgenerate

  always_comb begin
    dec_c = '0;
    case (in_op)
      3'd0:    dec_c.op_oh = OH_LT;
      3'd1:    dec_c.op_oh = OH_LTE;
      3'd2:    dec_c.op_oh = OH_EQ;
      3'd3:    dec_c.op_oh = OH_MIN;
      3'd4:    dec_c.op_oh = OH_MAX;
      default: dec_c.op_oh = 5'b00000;
    endcase
    dec_c.tag    = in_tag;
    dec_c.a      = in_a;
    dec_c.b      = in_b;
    dec_c.nan_a  = nan_a_c;
    dec_c.snan_a = snan_a_c;
    dec_c.nan_b  = nan_b_c;
    dec_c.snan_b = snan_b_c;
  end

  // ------------------------------------------------- stage 1 + plain stages
  stage_t fin_data;
  logic   fin_valid;

  generate
    if (LATENCY == 1) begin : g_lat1
      assign fin_data  = dec_c;
      assign fin_valid = in_valid;
    end else begin : g_pipe
      stage_t data_reg [LATENCY-1];
      logic   vld_reg  [LATENCY-1];

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < LATENCY-1; i++) begin
            data_reg[i] <= '0;
            vld_reg[i]  <= 1'b0;
          end
        end else if (adv) begin
          // in_ready equals adv, so in_valid here is an accepted operation.
          vld_reg[0] <= in_valid;
          if (in_valid) data_reg[0] <= dec_c;
          for (int i = 1; i < LATENCY-1; i++) begin
            vld_reg[i] <= vld_reg[i-1];
            if (vld_reg[i-1]) data_reg[i] <= data_reg[i-1];
          end
        end
      end

      assign fin_data  = data_reg[LATENCY-2];
      assign fin_valid = vld_reg[LATENCY-2];
    end
  endgenerate

  // ------------------------------------------------ final compare / select
  // Returns {nv, q} for one lane.
  function automatic logic [32:0] lane_eval(
    input logic [4:0]  op_oh,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        na,
    input logic        sna,
    input logic        nb,
    input logic        snb
  );
    logic        both_zero, lt_mm, lt_cmp, eq_cmp, any_nan, any_snan, nv;
    logic [31:0] q;
    both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    // Sign-magnitude order with -0 < +0 (what MIN/MAX want).
    if (a[31] != b[31]) lt_mm = a[31];
    else if (a[31])     lt_mm = a[30:0] > b[30:0];
    else                lt_mm = a[30:0] < b[30:0];
    // IEEE compares treat the two zeros as equal.
    lt_cmp   = lt_mm && !both_zero;
    eq_cmp   = (a == b) || both_zero;
    any_nan  = na || nb;
    any_snan = sna || snb;
    q  = 32'd0;
    nv = 1'b0;
    case (op_oh)
      OH_LT: begin
        q[0] = !any_nan && lt_cmp;
        nv   = any_nan;
      end
      OH_LTE: begin
        q[0] = !any_nan && (lt_cmp || eq_cmp);
        nv   = any_nan;
      end
      OH_EQ: begin
        q[0] = !any_nan && eq_cmp;
        nv   = any_snan;
      end
      OH_MIN: begin
        nv = any_snan;
        if (na && nb) q = 32'h7FC0_0000;
        else if (na)  q = b;
        else if (nb)  q = a;
        else          q = lt_mm ? a : b;
      end
      OH_MAX: begin
        nv = any_snan;
        if (na && nb) q = 32'h7FC0_0000;
        else if (na)  q = b;
        else if (nb)  q = a;
        else          q = lt_mm ? b : a;
      end
      default: begin
        q  = 32'd0;
        nv = 1'b1;
      end
    endcase
    return {nv, q};
  endfunction

  logic [LANES*32-1:0] res_q;
  logic [LANES-1:0]    res_nv;

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign {res_nv[gi], res_q[32*gi +: 32]} = lane_eval(
        fin_data.op_oh, fin_data.a[32*gi +: 32], fin_data.b[32*gi +: 32],
        fin_data.nan_a[gi], fin_data.snan_a[gi],
        fin_data.nan_b[gi], fin_data.snan_b[gi]);
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_q       <= '0;
      out_invalid <= '0;
      out_tag     <= '0;
    end else if (adv) begin
      out_valid <= fin_valid;
      if (fin_valid) begin
        out_q       <= res_q;
        out_invalid <= res_nv;
        out_tag     <= fin_data.tag;
      end
    end
  end

endmodule

// File: tb/tb_fp_compare_unit.sv
// Directed testbench for fp_compare_unit (LATENCY=2, LANES=4, TAG_WIDTH=8).
module tb_fp_compare_unit;

  localparam int LAT = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = 3'd0;
  logic [127:0] in_a = '0;
  logic [127:0] in_b = '0;
  logic [7:0]   in_tag = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_q;
  logic [3:0]   out_invalid;
  logic [7:0]   out_tag;

  int vectors = 0;
  int miscompares = 0;

  fp_compare_unit #(.LATENCY(LAT), .LANES(4), .TAG_WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_q       (out_q),
    .out_invalid (out_invalid),
    .out_tag     (out_tag)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  // Issue one op with out_ready=1, wait for the result, check latency and payload.
  task automatic do_op(input string name, input logic [2:0] op,
                       input logic [127:0] a, input logic [127:0] b,
                       input logic [7:0] tag,
                       input logic [127:0] exp_q, input logic [3:0] exp_nv);
    int n;
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    out_ready = 1'b1;
    #4;
    check({name, " in_ready"}, 128'(in_ready), 128'(1));
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, " latency"}, 128'(n), 128'(LAT));
    check({name, " q"}, out_q, exp_q);
    check({name, " nv"}, 128'(out_invalid), 128'(exp_nv));
    check({name, " tag"}, 128'(out_tag), 128'(tag));
  endtask

  initial begin
    logic [31:0] v;
    int idx;
    int rx;
    int extra;
    int seen;

    // ---------------- reset
    repeat (3) @(posedge clock);
    #1;
    check("rst out_valid", 128'(out_valid), 128'(0));
    check("rst out_q", out_q, 128'(0));
    check("rst out_tag", 128'(out_tag), 128'(0));
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("post-rst in_ready", 128'(in_ready), 128'(1));
    check("post-rst out_valid", 128'(out_valid), 128'(0));

    // ---------------- LTE / LT / EQ on {1.0,-0.0,2.0,-3.0} vs {1.0,+0.0,1.0,-2.0}
    do_op("lte", 3'd1,
          {32'hC0400000, 32'h40000000, 32'h80000000, 32'h3F800000},
          {32'hC0000000, 32'h3F800000, 32'h00000000, 32'h3F800000}, 8'h01,
          {32'h1, 32'h0, 32'h1, 32'h1}, 4'b0000);
    do_op("lt", 3'd0,
          {32'hC0400000, 32'h40000000, 32'h80000000, 32'h3F800000},
          {32'hC0000000, 32'h3F800000, 32'h00000000, 32'h3F800000}, 8'h02,
          {32'h1, 32'h0, 32'h0, 32'h0}, 4'b0000);
    do_op("eq", 3'd2,
          {32'hC0400000, 32'h40000000, 32'h80000000, 32'h3F800000},
          {32'hC0000000, 32'h3F800000, 32'h00000000, 32'h3F800000}, 8'h03,
          {32'h0, 32'h0, 32'h1, 32'h1}, 4'b0000);

    // ---------------- signed zeros in MIN/MAX
    do_op("min zeros", 3'd3, {4{32'h80000000}}, {4{32'h00000000}}, 8'h04,
          {4{32'h80000000}}, 4'b0000);
    do_op("max zeros", 3'd4, {4{32'h80000000}}, {4{32'h00000000}}, 8'h05,
          {4{32'h00000000}}, 4'b0000);

    // ---------------- NaN handling
    do_op("eq qnan", 3'd2, {4{32'h7FC00001}}, {4{32'h3F800000}}, 8'h06,
          128'd0, 4'b0000);
    do_op("lt qnan", 3'd0, {4{32'h7FC00001}}, {4{32'h3F800000}}, 8'h07,
          128'd0, 4'b1111);
    do_op("max snan", 3'd4, {4{32'h7F800001}}, {4{32'h40000000}}, 8'h08,
          {4{32'h40000000}}, 4'b1111);
    do_op("min qnan2", 3'd3, {4{32'h7FC00001}}, {4{32'h7FC00002}}, 8'h09,
          {4{32'h7FC00000}}, 4'b0000);
    // Mixed lanes: sNaN/2.0, 1.0/qNaN, qNaN/qNaN, subnormal 1 vs 2
    do_op("max mixed", 3'd4,
          {32'h00000001, 32'h7FC00000, 32'h3F800000, 32'h7F800001},
          {32'h00000002, 32'h7FC00001, 32'h7FC00001, 32'h40000000}, 8'h0A,
          {32'h00000002, 32'h7FC00000, 32'h3F800000, 32'h40000000}, 4'b0001);
    // Subnormals and infinities: -2ulp<-1ulp, +1ulp<-1ulp, -inf<+0, +inf<+inf
    do_op("lt subnorm", 3'd0,
          {32'h7F800000, 32'hFF800000, 32'h00000001, 32'h80000002},
          {32'h7F800000, 32'h00000000, 32'h80000001, 32'h80000001}, 8'h0B,
          {32'h0, 32'h1, 32'h0, 32'h1}, 4'b0000);

    // ---------------- reserved op
    do_op("rsvd op6", 3'd6, {4{32'h3F800000}}, {4{32'h3F800000}}, 8'h5A,
          128'd0, 4'b1111);

    // ---------------- back-pressure: 5 ops, out_ready=0 for cycles 3..6
    @(posedge clock); #1;
    idx = 0;
    rx = 0;
    extra = 0;
    for (int c = 0; c < 16; c++) begin
      out_ready = !(c >= 3 && c < 7);
      in_valid  = (idx < 5);
      in_op     = 3'd4;
      v         = 32'h3F800000 + 32'(idx);
      in_a      = {4{v}};
      in_b      = '0;
      in_tag    = 8'(8'h10 + idx);
      #4;
      check($sformatf("bp in_ready c%0d", c), 128'(in_ready), 128'(!(c >= 3 && c < 7)));
      if (out_valid === 1'b1) begin
        if (rx < 5) begin
          v = 32'h3F800000 + 32'(rx);
          check($sformatf("bp tag c%0d", c), 128'(out_tag), 128'(8'(8'h10 + rx)));
          check($sformatf("bp q c%0d", c), out_q, {4{v}});
          if (out_ready) rx++;
        end else begin
          extra++;
        end
      end
      if (in_valid && in_ready) idx++;
      @(posedge clock); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp results", 128'(rx), 128'(5));
    check("bp extra", 128'(extra), 128'(0));

    // ---------------- reset with two ops in flight
    in_valid = 1'b1; in_op = 3'd1; in_a = '0; in_b = '0; in_tag = 8'h20;
    @(posedge clock); #1;
    in_tag = 8'h21;
    @(posedge clock); #1;
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("midrst out_valid", 128'(out_valid), 128'(0));
    check("midrst out_q", out_q, 128'(0));
    check("midrst out_tag", 128'(out_tag), 128'(0));
    check("midrst out_invalid", 128'(out_invalid), 128'(0));
    @(negedge clock);
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (out_valid !== 1'b0) seen++;
    end
    check("midrst stale", 128'(seen), 128'(0));
    @(posedge clock); #1;
    do_op("post-rst lte", 3'd1, {4{32'h3F800000}}, {4{32'h40000000}}, 8'h33,
          {4{32'h1}}, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
